// File: rtl/player_track.sv
// Per-player vertical motion controller: clamped y per channel, manual or bounce
// movement, and a round-robin erase/redraw request queue toward the VGA drawer.
module player_track #(
  parameter int NUM_PLAYERS = 2,
  parameter int Y_WIDTH     = 8,
  parameter int X_WIDTH     = 9,
  parameter int Y_MIN       = 0,
  parameter int Y_MAX       = 230,
  parameter int Y_START     = 120,
  parameter int STEP        = 10,
  parameter int X_BASE      = 0,
  parameter int X_PITCH     = 310,
  localparam int CW         = (NUM_PLAYERS > 1) ? $clog2(NUM_PLAYERS) : 1
) (
  input  logic                           clk,
  input  logic                           reset,
  input  logic                           bounce_en,
  input  logic                           tick,
  input  logic [NUM_PLAYERS-1:0]         move_up,
  input  logic [NUM_PLAYERS-1:0]         move_down,
  output logic [NUM_PLAYERS*Y_WIDTH-1:0] y_bus,
  output logic [NUM_PLAYERS-1:0]         at_top,
  output logic [NUM_PLAYERS-1:0]         at_bottom,
  output logic                           draw_valid,
  input  logic                           draw_ready,
  output logic [CW-1:0]                  draw_chan,
  output logic [X_WIDTH-1:0]             draw_x,
  output logic [Y_WIDTH-1:0]             draw_old_y,
  output logic [Y_WIDTH-1:0]             draw_new_y
);

  localparam logic [Y_WIDTH-1:0] L_Y_MIN   = Y_WIDTH'(Y_MIN);
  localparam logic [Y_WIDTH-1:0] L_Y_MAX   = Y_WIDTH'(Y_MAX);
  localparam logic [Y_WIDTH-1:0] L_Y_START = Y_WIDTH'(Y_START);
  localparam logic [0:0] S_IDLE  = 1'b0;
  localparam logic [0:0] S_OFFER = 1'b1;

  logic [Y_WIDTH-1:0]     r_y       [NUM_PLAYERS];
  logic [Y_WIDTH-1:0]     r_drawn_y [NUM_PLAYERS];
  logic [NUM_PLAYERS-1:0] r_dir;
  logic [0:0]             r_state;
  logic [CW-1:0]          r_rr_ptr;
  logic                   r_draw_valid;
  logic [CW-1:0]          r_draw_chan;
  logic [X_WIDTH-1:0]     r_draw_x;
  logic [Y_WIDTH-1:0]     r_draw_old_y;
  logic [Y_WIDTH-1:0]     r_draw_new_y;

  logic [Y_WIDTH-1:0]     w_y_next [NUM_PLAYERS];
  logic [NUM_PLAYERS-1:0] w_dir_next;
  logic [NUM_PLAYERS-1:0] w_dir_eff;
  logic [NUM_PLAYERS-1:0] w_dirty;
  logic                   w_any_dirty;
  logic [CW-1:0]          w_pick;
  logic [Y_WIDTH-1:0]     w_pick_y;
  logic [Y_WIDTH-1:0]     w_pick_old;
  logic [X_WIDTH-1:0]     w_pick_x;

  // Arithmetic is done in 32 bits so the clamp test can never wrap.
  function automatic logic [Y_WIDTH-1:0] step_up(input logic [Y_WIDTH-1:0] y);
    logic [31:0] v;
    v = 32'(y);
    if (v < 32'(Y_MIN) + 32'(STEP)) return L_Y_MIN;
    else return Y_WIDTH'(v - 32'(STEP));
  endfunction

  function automatic logic [Y_WIDTH-1:0] step_down(input logic [Y_WIDTH-1:0] y);
    logic [31:0] v;
    v = 32'(y);
    if (v + 32'(STEP) > 32'(Y_MAX)) return L_Y_MAX;
    else return Y_WIDTH'(v + 32'(STEP));
  endfunction

  always_comb begin
    w_dir_eff  = r_dir;
    w_dir_next = r_dir;
    for (int i = 0; i < NUM_PLAYERS; i++) begin
      w_y_next[i] = r_y[i];
      if (move_up[i] && !move_down[i]) w_dir_eff[i] = 1'b0;
      else if (move_down[i] && !move_up[i]) w_dir_eff[i] = 1'b1;
      else w_dir_eff[i] = r_dir[i];

      if (!bounce_en) begin
        if (move_up[i] && !move_down[i]) w_y_next[i] = step_up(r_y[i]);
        else if (move_down[i] && !move_up[i]) w_y_next[i] = step_down(r_y[i]);
        else w_y_next[i] = r_y[i];
        w_dir_next[i] = r_dir[i];
      end else if (tick) begin
        // A same-cycle direction pulse steers this tick; landing on a limit flips.
        w_y_next[i] = w_dir_eff[i] ? step_down(r_y[i]) : step_up(r_y[i]);
        if (w_y_next[i] == L_Y_MIN) w_dir_next[i] = 1'b1;
        else if (w_y_next[i] == L_Y_MAX) w_dir_next[i] = 1'b0;
        else w_dir_next[i] = w_dir_eff[i];
      end else begin
        w_y_next[i]   = r_y[i];
        w_dir_next[i] = w_dir_eff[i];
      end
    end
  end

  always_comb begin
    y_bus       = '0;
    at_top      = '0;
    at_bottom   = '0;
    w_dirty     = '0;
    for (int i = 0; i < NUM_PLAYERS; i++) begin
      y_bus[i*Y_WIDTH +: Y_WIDTH] = r_y[i];
      at_top[i]    = (r_y[i] == L_Y_MIN);
      at_bottom[i] = (r_y[i] == L_Y_MAX);
      w_dirty[i]   = (r_y[i] != r_drawn_y[i]);
    end
    w_any_dirty = |w_dirty;
  end

  // Round-robin search: the smallest offset after the last grant wins.
  always_comb begin
    w_pick     = r_rr_ptr;
    w_pick_y   = '0;
    w_pick_old = '0;
    for (int k = NUM_PLAYERS; k >= 1; k--) begin
      for (int j = 0; j < NUM_PLAYERS; j++) begin
        if (j == (int'(r_rr_ptr) + k) % NUM_PLAYERS && w_dirty[j]) w_pick = CW'(j);
        else w_pick = w_pick;
      end
    end
    for (int j = 0; j < NUM_PLAYERS; j++) begin
      if (CW'(j) == w_pick) begin
        w_pick_y   = r_y[j];
        w_pick_old = r_drawn_y[j];
      end else begin
        w_pick_y   = w_pick_y;
      end
    end
    w_pick_x = X_WIDTH'(X_BASE + int'(w_pick) * X_PITCH);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < NUM_PLAYERS; i++) r_y[i] <= L_Y_START;
      r_dir <= '0;
    end else begin
      for (int i = 0; i < NUM_PLAYERS; i++) r_y[i] <= w_y_next[i];
      r_dir <= w_dir_next;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < NUM_PLAYERS; i++) r_drawn_y[i] <= L_Y_START;
      r_state      <= S_IDLE;
      r_rr_ptr     <= CW'(NUM_PLAYERS - 1);
      r_draw_valid <= 1'b0;
      r_draw_chan  <= '0;
      r_draw_x     <= '0;
      r_draw_old_y <= '0;
      r_draw_new_y <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_any_dirty) begin
            r_draw_chan  <= w_pick;
            r_draw_x     <= w_pick_x;
            r_draw_old_y <= w_pick_old;
            r_draw_new_y <= w_pick_y;
            r_rr_ptr     <= w_pick;
            r_draw_valid <= 1'b1;
            r_state      <= S_OFFER;
          end
        end
        S_OFFER: begin
          if (draw_ready) begin
            for (int j = 0; j < NUM_PLAYERS; j++) begin
              if (CW'(j) == r_draw_chan) r_drawn_y[j] <= r_draw_new_y;
            end
            r_draw_valid <= 1'b0;
            r_state      <= S_IDLE;
          end
        end
        default: begin
          r_draw_valid <= 1'b0;
          r_state      <= S_IDLE;
        end
      endcase
    end
  end

  assign draw_valid = r_draw_valid;
  assign draw_chan  = r_draw_chan;
  assign draw_x     = r_draw_x;
  assign draw_old_y = r_draw_old_y;
  assign draw_new_y = r_draw_new_y;

endmodule

// File: tb/tb_player_track.sv
// Directed bench for player_track with default parameters: reset, manual moves,
// draw handshake stall, round-robin fairness, bounce, and reset during an offer.
module tb_player_track;
  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        bounce_en = 1'b0;
  logic        tick = 1'b0;
  logic [1:0]  move_up = 2'b00;
  logic [1:0]  move_down = 2'b00;
  logic [15:0] y_bus;
  logic [1:0]  at_top, at_bottom;
  logic        draw_valid;
  logic        draw_ready = 1'b0;
  logic [0:0]  draw_chan;
  logic [8:0]  draw_x;
  logic [7:0]  draw_old_y, draw_new_y;

  int n_checks = 0;
  int n_errors = 0;

  player_track dut (
    .clk(clk), .reset(reset), .bounce_en(bounce_en), .tick(tick),
    .move_up(move_up), .move_down(move_down), .y_bus(y_bus),
    .at_top(at_top), .at_bottom(at_bottom), .draw_valid(draw_valid),
    .draw_ready(draw_ready), .draw_chan(draw_chan), .draw_x(draw_x),
    .draw_old_y(draw_old_y), .draw_new_y(draw_new_y)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input int obs, input int exp);
    n_checks++;
    if (obs != exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic pulse(input logic [1:0] up, input logic [1:0] dn, input logic tk);
    move_up = up; move_down = dn; tick = tk;
    step();
    move_up = 2'b00; move_down = 2'b00; tick = 1'b0;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    step();
    reset = 1'b0;
  endtask

  task automatic check_offer(input string tag, input int ch, input int x, input int o, input int n);
    check({tag, "_valid"}, int'(draw_valid), 1);
    check({tag, "_chan"}, int'(draw_chan), ch);
    check({tag, "_x"}, int'(draw_x), x);
    check({tag, "_old"}, int'(draw_old_y), o);
    check({tag, "_new"}, int'(draw_new_y), n);
  endtask

  initial begin
    int ey, ed, e0, e1;
    // Reset state
    step(); step();
    reset = 1'b0;
    check("rst_y0", int'(y_bus[7:0]), 120);
    check("rst_y1", int'(y_bus[15:8]), 120);
    check("rst_top", int'(at_top), 0);
    check("rst_bot", int'(at_bottom), 0);
    check("rst_chan", int'(draw_chan), 0);
    check("rst_x", int'(draw_x), 0);
    for (int i = 0; i < 20; i++) begin
      check("rst_idle_valid", int'(draw_valid), 0);
      step();
    end

    // Manual: ch0 up to the top limit, then held there
    draw_ready = 1'b1;
    for (int n = 1; n <= 13; n++) begin
      pulse(2'b01, 2'b00, 1'b0);
      check("man_y0", int'(y_bus[7:0]), (120 - 10*n < 0) ? 0 : 120 - 10*n);
      check("man_top0", int'(at_top[0]), (n >= 12) ? 1 : 0);
    end
    pulse(2'b10, 2'b10, 1'b0);
    check("man_both_y1", int'(y_bus[15:8]), 120);
    pulse(2'b00, 2'b10, 1'b0);
    check("man_down_y1", int'(y_bus[15:8]), 130);
    pulse(2'b00, 2'b00, 1'b1);
    check("man_tick_y0", int'(y_bus[7:0]), 0);
    check("man_tick_y1", int'(y_bus[15:8]), 130);

    // Handshake stalled by draw_ready low
    draw_ready = 1'b0;
    do_reset();
    pulse(2'b01, 2'b00, 1'b0);
    check("hs_lat_valid0", int'(draw_valid), 0);
    step();
    check_offer("hs1", 0, 0, 120, 110);
    pulse(2'b01, 2'b00, 1'b0);
    check_offer("hs_stall_a", 0, 0, 120, 110);
    pulse(2'b01, 2'b00, 1'b0);
    check_offer("hs_stall_b", 0, 0, 120, 110);
    check("hs_y0", int'(y_bus[7:0]), 90);
    draw_ready = 1'b1;
    step();
    check("hs_gap_valid", int'(draw_valid), 0);
    draw_ready = 1'b0;
    step();
    check_offer("hs2", 0, 0, 110, 90);
    draw_ready = 1'b1;
    step();
    check("hs2_done", int'(draw_valid), 0);
    step(); step();
    check("hs_clean", int'(draw_valid), 0);

    // Round-robin fairness with ready held high
    do_reset();
    for (int r = 0; r < 2; r++) begin
      pulse(2'b11, 2'b00, 1'b0);
      step();
      check_offer("rr_ch0", 0, 0, 120 - 10*r, 110 - 10*r);
      step();
      check("rr_gap0", int'(draw_valid), 0);
      step();
      check_offer("rr_ch1", 1, 310, 120 - 10*r, 110 - 10*r);
      step();
      check("rr_gap1", int'(draw_valid), 0);
    end

    // Bounce sweep: 0 flips downward, 230 (clamped) flips upward
    do_reset();
    bounce_en = 1'b1;
    ey = 120; ed = 0;
    for (int t = 1; t <= 40; t++) begin
      pulse(2'b00, 2'b00, 1'b1);
      if (ed == 0) ey = (ey < 10) ? 0 : ey - 10;
      else ey = (ey > 220) ? 230 : ey + 10;
      if (ey == 0) ed = 1;
      else if (ey == 230) ed = 0;
      check("bn_y0", int'(y_bus[7:0]), ey);
      check("bn_y1", int'(y_bus[15:8]), ey);
      check("bn_top", int'(at_top[0]), (ey == 0) ? 1 : 0);
      check("bn_bot", int'(at_bottom[1]), (ey == 230) ? 1 : 0);
    end
    e0 = 180; e1 = 180;
    check("bn_end_y0", int'(y_bus[7:0]), e0);
    pulse(2'b00, 2'b01, 1'b0);
    check("bn_dir_nomove", int'(y_bus[7:0]), e0);
    pulse(2'b00, 2'b00, 1'b1);
    check("bn_dir_y0", int'(y_bus[7:0]), 190);
    check("bn_dir_y1", int'(y_bus[15:8]), 170);
    pulse(2'b01, 2'b00, 1'b1);
    check("bn_prio_y0", int'(y_bus[7:0]), 180);
    check("bn_prio_y1", int'(y_bus[15:8]), 160);
    bounce_en = 1'b0;
    pulse(2'b00, 2'b00, 1'b1);
    check("bn_off_y0", int'(y_bus[7:0]), 180);

    // Reset asserted mid-offer
    draw_ready = 1'b0;
    do_reset();
    pulse(2'b01, 2'b00, 1'b0);
    step();
    check("ro_valid_pre", int'(draw_valid), 1);
    #2;
    reset = 1'b1;
    #1;
    check("ro_valid_async", int'(draw_valid), 0);
    check("ro_y0_async", int'(y_bus[7:0]), 120);
    step();
    reset = 1'b0;
    draw_ready = 1'b1;
    for (int i = 0; i < 5; i++) begin
      step();
      check("ro_no_stale", int'(draw_valid), 0);
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule
